// File: rtl/ahb_sram_defs.sv
// Shared encodings for the AHB-lite SRAM bridge: bus field values, byte-lane decode,
// and the error response state machine encoding.
package ahb_sram_defs;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        ERR_IDLE = 2'b00,
        ERR_ONE  = 2'b01,
        ERR_TWO  = 2'b10
    } err_state_e;

    // Sizes above word are handled as full-word accesses.
    function automatic logic [3:0] lane_decode(input logic [2:0] hsize, input logic [1:0] addr_lo);
        logic [3:0] lanes;
        case (hsize)
            HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
            HSIZE_HALF: lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/ahb_sram_chk.sv
// Run-time invariants of the write park buffer; carries no functional logic.
module ahb_sram_chk (
    input logic clk,
    input logic rst,
    input logic wr_dph,
    input logic buf_valid,
    input logic direct_wr,
    input logic drain
);

    // A write data phase must always find the park buffer empty.
    a_buf_empty_at_write: assert property (@(posedge clk) disable iff (rst) wr_dph |-> !buf_valid);

    // The SRAM port carries at most one write per cycle.
    a_no_double_write: assert property (@(posedge clk) disable iff (rst) !(direct_wr && drain));

endmodule

// File: rtl/ahb_sram_wbuf.sv
// One-entry write park buffer with drain request and read-after-write forward capture.
module ahb_sram_wbuf
    import ahb_sram_defs::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_acc,
    input  logic [AW-1:0] rd_addr,
    input  logic          wr_dph,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_lanes,
    input  logic [31:0]   wr_data,
    output logic          buf_valid,
    output logic [AW-1:0] buf_addr,
    output logic [3:0]    buf_lanes,
    output logic [31:0]   buf_data,
    output logic          drain_req,
    output logic [3:0]    fwd_lanes,
    output logic [31:0]   fwd_data
);

    logic          buf_valid_r;
    logic [AW-1:0] buf_addr_r;
    logic [3:0]    buf_lanes_r;
    logic [31:0]   buf_data_r;
    logic [3:0]    fwd_lanes_r;
    logic [31:0]   fwd_data_r;

    logic          park_s;
    logic          nxt_valid_s;
    logic [AW-1:0] nxt_addr_s;
    logic [3:0]    nxt_lanes_s;
    logic [31:0]   nxt_data_s;

    assign park_s    = wr_dph & rd_acc & ~rst;
    assign drain_req = buf_valid_r & ~rd_acc & ~wr_dph & ~rst;

    // Next buffer contents; forwarding samples this so a write parked in the
    // same cycle as the read is already visible to it.
    always_comb begin
        nxt_valid_s = buf_valid_r;
        nxt_addr_s  = buf_addr_r;
        nxt_lanes_s = buf_lanes_r;
        nxt_data_s  = buf_data_r;
        if (park_s) begin
            nxt_valid_s = 1'b1;
            nxt_addr_s  = wr_addr;
            nxt_lanes_s = wr_lanes;
            nxt_data_s  = wr_data;
        end else if (drain_req) begin
            nxt_valid_s = 1'b0;
        end else begin
            nxt_valid_s = buf_valid_r;
        end
    end

    // Buffer and forward registers; reset discards any parked write.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_r <= 1'b0;
            buf_addr_r  <= '0;
            buf_lanes_r <= 4'd0;
            buf_data_r  <= 32'd0;
            fwd_lanes_r <= 4'd0;
            fwd_data_r  <= 32'd0;
        end else begin
            buf_valid_r <= nxt_valid_s;
            buf_addr_r  <= nxt_addr_s;
            buf_lanes_r <= nxt_lanes_s;
            buf_data_r  <= nxt_data_s;
            if (rd_acc) begin
                fwd_lanes_r <= (nxt_valid_s && (nxt_addr_s == rd_addr)) ? nxt_lanes_s : 4'd0;
                fwd_data_r  <= nxt_data_s;
            end
        end
    end

    assign buf_valid = buf_valid_r;
    assign buf_addr  = buf_addr_r;
    assign buf_lanes = buf_lanes_r;
    assign buf_data  = buf_data_r;
    assign fwd_lanes = fwd_lanes_r;
    assign fwd_data  = fwd_data_r;

endmodule

// File: rtl/ahb_sram_ctrl.sv
// Zero-wait-state AHB-lite slave for the 3K x 32 single-port SRAM.
// Optional out-of-range error response is enabled by defining AHB_SRAM_ERR_EN.
module ahb_sram_ctrl
    import ahb_sram_defs::*;
#(
    parameter int AW    = 12,
    parameter int DEPTH = 3072
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic [31:0]   HRDATA,
    output logic          HRESP,
    input  logic [31:0]   SRAMRDATA,
    output logic [3:0]    SRAMWEN,
    output logic [31:0]   SRAMWDATA,
    output logic          SRAMCS0,
    output logic [AW-1:0] SRAMADDR
);

    logic          accept_s;
    logic [AW-1:0] word_s;
    logic [3:0]    lanes_s;
    logic          range_err_s;
    logic          rd_acc_s;
    logic          wr_acc_s;
    logic          direct_wr_s;
    logic          unused_ok_s;

    logic          rd_dph_r;
    logic          wr_dph_r;
    logic [AW-1:0] wr_addr_r;
    logic [3:0]    wr_lanes_r;

    logic          buf_valid_s;
    logic [AW-1:0] buf_addr_s;
    logic [3:0]    buf_lanes_s;
    logic [31:0]   buf_data_s;
    logic          drain_s;
    logic [3:0]    fwd_lanes_s;
    logic [31:0]   fwd_data_s;

    logic          cs_s;
    logic [3:0]    wen_s;
    logic [AW-1:0] addr_s;
    logic [31:0]   wdata_s;
    logic [31:0]   hrdata_s;

    assign accept_s    = HSEL & HREADY & HTRANS[1] & ~HRESET;
    assign word_s      = HADDR[AW+1:2];
    assign lanes_s     = lane_decode(HSIZE, HADDR[1:0]);
    assign unused_ok_s = ^{HADDR[31:AW+2], HTRANS[0]};

`ifdef AHB_SRAM_ERR_EN
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    err_state_e err_state_r;
    logic       hreadyout_r;
    logic       hresp_r;

    assign range_err_s = accept_s & ({1'b0, word_s} >= DEPTH_W);

    // Two-cycle ERROR response; the failing access never reaches the SRAM.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_state_r <= ERR_IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
        end else begin
            case (err_state_r)
                ERR_IDLE, ERR_TWO: begin
                    if (range_err_s) begin
                        err_state_r <= ERR_ONE;
                        hreadyout_r <= 1'b0;
                        hresp_r     <= 1'b1;
                    end else begin
                        err_state_r <= ERR_IDLE;
                        hreadyout_r <= 1'b1;
                        hresp_r     <= 1'b0;
                    end
                end
                ERR_ONE: begin
                    err_state_r <= ERR_TWO;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= 1'b1;
                end
                default: begin
                    err_state_r <= ERR_IDLE;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= 1'b0;
                end
            endcase
        end
    end

    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;
`else
    assign range_err_s = 1'b0;
    assign HREADYOUT   = 1'b1;
    assign HRESP       = 1'b0;
`endif

    assign rd_acc_s    = accept_s & ~HWRITE & ~range_err_s;
    assign wr_acc_s    = accept_s &  HWRITE & ~range_err_s;
    assign direct_wr_s = wr_dph_r & ~rd_acc_s & ~HRESET;

    // Data-phase tracking; a stalled bus holds the current phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rd_dph_r   <= 1'b0;
            wr_dph_r   <= 1'b0;
            wr_addr_r  <= '0;
            wr_lanes_r <= 4'd0;
        end else if (HREADY) begin
            rd_dph_r <= rd_acc_s;
            wr_dph_r <= wr_acc_s;
            if (wr_acc_s) begin
                wr_addr_r  <= word_s;
                wr_lanes_r <= lanes_s;
            end
        end
    end

    ahb_sram_wbuf #(
        .AW(AW)
    ) u_wbuf (
        .clk       (HCLK),
        .rst       (HRESET),
        .rd_acc    (rd_acc_s),
        .rd_addr   (word_s),
        .wr_dph    (wr_dph_r),
        .wr_addr   (wr_addr_r),
        .wr_lanes  (wr_lanes_r),
        .wr_data   (HWDATA),
        .buf_valid (buf_valid_s),
        .buf_addr  (buf_addr_s),
        .buf_lanes (buf_lanes_s),
        .buf_data  (buf_data_s),
        .drain_req (drain_s),
        .fwd_lanes (fwd_lanes_s),
        .fwd_data  (fwd_data_s)
    );

    // SRAM port arbitration: read, then direct write, then buffer drain.
    always_comb begin
        cs_s    = 1'b0;
        wen_s   = 4'd0;
        addr_s  = '0;
        wdata_s = 32'd0;
        if (rd_acc_s) begin
            cs_s   = 1'b1;
            addr_s = word_s;
        end else if (direct_wr_s) begin
            cs_s    = 1'b1;
            wen_s   = wr_lanes_r;
            addr_s  = wr_addr_r;
            wdata_s = HWDATA;
        end else if (drain_s) begin
            cs_s    = 1'b1;
            wen_s   = buf_lanes_s;
            addr_s  = buf_addr_s;
            wdata_s = buf_data_s;
        end else begin
            cs_s = 1'b0;
        end
    end

    // Read data merges forwarded bytes over the SRAM word.
    always_comb begin
        hrdata_s = 32'd0;
        if (rd_dph_r) begin
            for (int i = 0; i < 4; i++) begin
                hrdata_s[8*i +: 8] = fwd_lanes_s[i] ? fwd_data_s[8*i +: 8] : SRAMRDATA[8*i +: 8];
            end
        end else begin
            hrdata_s = 32'd0;
        end
    end

    assign SRAMCS0   = cs_s;
    assign SRAMWEN   = wen_s;
    assign SRAMADDR  = addr_s;
    assign SRAMWDATA = wdata_s;
    assign HRDATA    = hrdata_s;

    ahb_sram_chk u_chk (
        .clk       (HCLK),
        .rst       (HRESET),
        .wr_dph    (wr_dph_r),
        .buf_valid (buf_valid_s),
        .direct_wr (direct_wr_s),
        .drain     (drain_s)
    );

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Scoreboard bench for ahb_sram_ctrl: directed cases then randomized traffic against a
// word-array memory model; a negedge monitor pops expected read data.
module tb_ahb_sram_ctrl;

    localparam int AW    = 12;
    localparam int DEPTH = 3072;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          hready;
    logic          HREADYOUT;
    logic [31:0]   HRDATA;
    logic          HRESP;
    logic [31:0]   SRAMRDATA;
    logic [3:0]    SRAMWEN;
    logic [31:0]   SRAMWDATA;
    logic          SRAMCS0;
    logic [AW-1:0] SRAMADDR;

    assign hready = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb_sram_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (hready),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP),
        .SRAMRDATA (SRAMRDATA),
        .SRAMWEN   (SRAMWEN),
        .SRAMWDATA (SRAMWDATA),
        .SRAMCS0   (SRAMCS0),
        .SRAMADDR  (SRAMADDR)
    );

    // Synchronous SRAM environment model.
    logic [31:0] sram [0:4095];
    always @(posedge HCLK) begin
        if (SRAMCS0) begin
            if (SRAMWEN != 4'd0) begin
                for (int b = 0; b < 4; b++)
                    if (SRAMWEN[b]) sram[SRAMADDR][8*b +: 8] <= SRAMWDATA[8*b +: 8];
            end else begin
                SRAMRDATA <= sram[SRAMADDR];
            end
        end
    end

    // Reference model: bus-visible memory contents plus one in-flight write.
    logic [31:0] ref_mem [0:4095];
    logic [31:0] exp_q [$];
    bit          pend_v;
    logic [11:0] pend_word;
    logic [3:0]  pend_lanes;
    logic [31:0] pend_data;
    bit          mon_en;
    bit          mon_rd_dph;
    int          n_checks;
    int          n_pass;

    logic          s_cs, s_ready, s_resp;
    logic [3:0]    s_wen;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata, s_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [3:0] lanes_of(input logic [2:0] size, input logic [31:0] addr);
        int n, base;
        logic [3:0] l;
        n    = (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
        base = (int'(addr[1:0]) / n) * n;
        l    = 4'd0;
        for (int i = 0; i < n; i++) l[base+i] = 1'b1;
        return l;
    endfunction

    // One bus cycle: kind 0 idle, 1 write, 2 read. wdata goes out in the next cycle.
    task automatic step(input bit rst, input int kind, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata);
        bit rd_next;
        logic [11:0] w;
        rd_next = 1'b0;
        w = addr[13:2];
        if (pend_v && !rst) begin
            for (int b = 0; b < 4; b++)
                if (pend_lanes[b]) ref_mem[pend_word][8*b +: 8] = pend_data[8*b +: 8];
        end
        HWDATA = pend_data;
        pend_v = 1'b0;
        HRESET = rst;
        HSEL   = (kind != 0);
        HTRANS = (kind != 0) ? 2'b10 : 2'b00;
        HWRITE = (kind == 1);
        HADDR  = addr;
        HSIZE  = size;
        if (!rst && kind == 1) begin
            pend_v     = 1'b1;
            pend_word  = w;
            pend_lanes = lanes_of(size, addr);
            pend_data  = wdata;
        end
        if (!rst && kind == 2 && int'(w) < DEPTH) begin
            exp_q.push_back(ref_mem[w]);
            rd_next = 1'b1;
        end
        #2;
        s_cs = SRAMCS0; s_wen = SRAMWEN; s_addr = SRAMADDR; s_wdata = SRAMWDATA;
        s_ready = HREADYOUT; s_resp = HRESP; s_rdata = HRDATA;
        @(posedge HCLK);
        mon_rd_dph = rd_next;
        #1;
    endtask

    // Monitor: pops the scoreboard in every read data phase.
    always @(negedge HCLK) begin
        if (mon_en) begin
            if (mon_rd_dph) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_pop: HRDATA %h with no expected entry", HRDATA);
                end else begin
                    check("hrdata", HRDATA, exp_q.pop_front());
                end
            end else begin
                check("hrdata_idle", HRDATA, 32'd0);
            end
`ifndef AHB_SRAM_ERR_EN
            check("hreadyout", {31'd0, HREADYOUT}, 32'd1);
            check("hresp", {31'd0, HRESP}, 32'd0);
`endif
        end
    end

    initial begin
        logic [31:0] addr, wd, old40;
        logic [2:0]  sz;
        int          kind;
        n_checks = 0; n_pass = 0; mon_en = 1'b0; mon_rd_dph = 1'b0; pend_v = 1'b0;
        pend_data = 32'd0;
        for (int i = 0; i < 4096; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        sram[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
        old40 = ref_mem[16];
        HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'd0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'd2; HWDATA = 32'd0;

        // Reset state
        @(posedge HCLK); @(posedge HCLK); #1;
        check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("rst_hresp", {31'd0, HRESP}, 32'd0);
        check("rst_cs", {31'd0, SRAMCS0}, 32'd0);
        check("rst_wen", {28'd0, SRAMWEN}, 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        HRESET = 1'b0;
        mon_en = 1'b1;

        // Word write then idle: direct write in the data phase
        step(0, 1, 32'h10, 3'd2, 32'hDEADBEEF);
        step(0, 0, 32'h0, 3'd2, 32'h0);
        check("dw_cs", {31'd0, s_cs}, 32'd1);
        check("dw_wen", {28'd0, s_wen}, 32'hF);
        check("dw_addr", {20'd0, s_addr}, 32'd4);
        check("dw_wdata", s_wdata, 32'hDEADBEEF);
        step(0, 2, 32'h10, 3'd2, 32'h0);
        step(0, 0, 32'h0, 3'd2, 32'h0);

        // Byte write followed by read of the same word: parked and forwarded
        step(0, 1, 32'h21, 3'd0, 32'h0000AA00);
        step(0, 2, 32'h20, 3'd2, 32'h0);
        check("park_cs", {31'd0, s_cs}, 32'd1);
        check("park_wen", {28'd0, s_wen}, 32'd0);
        check("park_addr", {20'd0, s_addr}, 32'd8);
        step(0, 0, 32'h0, 3'd2, 32'h0);
        check("drain_wen", {28'd0, s_wen}, 32'b0010);
        check("drain_addr", {20'd0, s_addr}, 32'd8);
        check("drain_byte", {24'd0, s_wdata[15:8]}, 32'hAA);

        // Parked write survives back-to-back reads, drains on idle
        step(0, 1, 32'h0, 3'd2, 32'hCAFEF00D);
        step(0, 2, 32'h4, 3'd2, 32'h0);
        step(0, 2, 32'h8, 3'd2, 32'h0);
        check("hold_wen_r2", {28'd0, s_wen}, 32'd0);
        step(0, 2, 32'hC, 3'd2, 32'h0);
        check("hold_wen_r3", {28'd0, s_wen}, 32'd0);
        step(0, 0, 32'h0, 3'd2, 32'h0);
        check("late_drain_wen", {28'd0, s_wen}, 32'hF);
        check("late_drain_addr", {20'd0, s_addr}, 32'd0);
        step(0, 2, 32'h0, 3'd2, 32'h0);
        step(0, 0, 32'h0, 3'd2, 32'h0);

        // Reset in the cycle the write would be parked: write is lost
        step(0, 1, 32'h40, 3'd2, 32'h55AA55AA);
        step(1, 2, 32'h44, 3'd2, 32'h0);
        check("rstpark_wen", {28'd0, s_wen}, 32'd0);
        step(0, 0, 32'h0, 3'd2, 32'h0);
        check("rstpark_cs", {31'd0, s_cs}, 32'd0);
        check("rstpark_hrdata", s_rdata, 32'd0);
        check("rstpark_model_old", ref_mem[16], old40);
        step(0, 2, 32'h40, 3'd2, 32'h0);
        step(0, 0, 32'h0, 3'd2, 32'h0);

`ifdef AHB_SRAM_ERR_EN
        // Out-of-range read: two-cycle ERROR with no SRAM access
        step(0, 2, 32'h3000, 3'd2, 32'h0);
        check("err_cs", {31'd0, s_cs}, 32'd0);
        step(0, 0, 32'h0, 3'd2, 32'h0);
        check("err1_ready", {31'd0, s_ready}, 32'd0);
        check("err1_resp", {31'd0, s_resp}, 32'd1);
        step(0, 0, 32'h0, 3'd2, 32'h0);
        check("err2_ready", {31'd0, s_ready}, 32'd1);
        check("err2_resp", {31'd0, s_resp}, 32'd1);
        step(0, 0, 32'h0, 3'd2, 32'h0);
        check("err_done_resp", {31'd0, s_resp}, 32'd0);
`endif

        // Randomized traffic over a small window to force collisions
        for (int n = 0; n < 600; n++) begin
            kind = int'($urandom_range(0, 9));
            kind = (kind < 3) ? 0 : (kind < 6) ? 1 : 2;
            sz   = 3'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 15)) * 32'd4;
            if (sz == 3'd0) addr = addr + 32'($urandom_range(0, 3));
            else if (sz == 3'd1) addr = addr + 32'($urandom_range(0, 1)) * 32'd2;
            wd = $urandom;
            step(0, kind, addr, sz, wd);
        end
        for (int i = 0; i < 16; i++) step(0, 2, 32'(i) * 32'd4, 3'd2, 32'h0);
        step(0, 0, 32'h0, 3'd2, 32'h0);
        step(0, 0, 32'h0, 3'd2, 32'h0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
